// File: rtl/pc_pkg.sv
// Shared state encoding, step constant and branch displacement helper for the PC unit.
package pc_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } pc_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Word offset to byte displacement: sign-extend and scale by 4.
  function automatic logic [31:0] branch_disp(input logic [15:0] offset);
    return {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational fetch-target arithmetic: sequential, branch and jump targets.
module pc_target_calc
  import pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [15:0] branch_offset,
  input  logic [25:0] jump_index,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target
);

  // All sums wrap modulo 2^32 by construction of the 32-bit result.
  assign pc_plus4      = pc + PC_STEP;
  assign branch_target = pc_plus4 + branch_disp(branch_offset);
  assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

endmodule

// File: rtl/pc_next_unit.sv
// Program counter sequencer: boot delay, run/stall, halt/resume and retired-advance counter.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted,
  output logic [31:0] retired_count
);

  localparam logic [3:0] BootLast = 4'(START_DELAY);

  pc_state_e   state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] branch_target, jump_target, pc_sel;

  pc_target_calc u_target_calc (
    .pc            (pc_q),
    .branch_offset (branch_offset),
    .jump_index    (jump_index),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .jump_target   (jump_target)
  );

  always_comb begin
    if (jump) begin
      pc_sel = jump_target;
    end else if (branch_taken) begin
      pc_sel = branch_target;
    end else begin
      pc_sel = pc_plus4;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    retired_d  = retired_q;
    unique case (state_q)
      StBoot: begin
        // Counter runs 0..START_DELAY, so RUN starts START_DELAY+1 edges after release.
        if (boot_cnt_q == BootLast) begin
          state_d    = StRun;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      StRun: begin
        if (halt_req) begin
          state_d = StHalt;
        end else if (!stall) begin
          pc_d      = pc_sel;
          retired_d = retired_q + 32'd1;
        end
      end
      StHalt: begin
        if (resume && !halt_req) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StBoot;
      boot_cnt_q <= '0;
      pc_q       <= RESET_PC;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      retired_q  <= retired_d;
    end
  end

  assign pc            = pc_q;
  assign retired_count = retired_q;
  assign fetch_valid   = (state_q == StRun);
  assign halted        = (state_q == StHalt);

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: three instances with different reset PCs share stimulus.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, branch_taken, jump, halt_req, resume;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;

  logic [31:0] a_pc, a_pc_plus4, a_retired;
  logic        a_fetch_valid, a_halted;
  logic [31:0] b_pc, b_pc_plus4, b_retired;
  logic        b_fetch_valid, b_halted;
  logic [31:0] c_pc, c_pc_plus4, c_retired;
  logic        c_fetch_valid, c_halted;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  always #5 clk = ~clk;

  pc_next_unit #(.RESET_PC(32'h0040_0000), .START_DELAY(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .halt_req(halt_req), .resume(resume), .pc(a_pc), .pc_plus4(a_pc_plus4),
    .fetch_valid(a_fetch_valid), .halted(a_halted), .retired_count(a_retired)
  );

  pc_next_unit #(.RESET_PC(32'h8FFF_FFF4), .START_DELAY(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .halt_req(halt_req), .resume(resume), .pc(b_pc), .pc_plus4(b_pc_plus4),
    .fetch_valid(b_fetch_valid), .halted(b_halted), .retired_count(b_retired)
  );

  pc_next_unit #(.RESET_PC(32'hFFFF_FFF8), .START_DELAY(1)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index),
    .halt_req(halt_req), .resume(resume), .pc(c_pc), .pc_plus4(c_pc_plus4),
    .fetch_valid(c_fetch_valid), .halted(c_halted), .retired_count(c_retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b1;
    {stall, branch_taken, jump, halt_req, resume} = '0;
    branch_offset = '0;
    jump_index    = '0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_pc", a_pc, 32'h0040_0000);
    check("rst_retired", a_retired, 32'd0);
    check("rst_fetch_valid", 32'(a_fetch_valid), 32'd0);
    check("rst_halted", 32'(a_halted), 32'd0);
    step();
    step();
    reset_n = 1'b1;

    // Boot: START_DELAY+1 edges with pc held.
    step();
    check("boot_e1_pc", a_pc, 32'h0040_0000);
    check("boot_e1_fv", 32'(a_fetch_valid), 32'd0);
    step();
    check("boot_e2_pc", a_pc, 32'h0040_0000);
    check("run_entry_fv", 32'(a_fetch_valid), 32'd1);
    step();
    check("seq1_pc", a_pc, 32'h0040_0004);
    step();
    check("seq2_pc", a_pc, 32'h0040_0008);
    check("seq2_retired", a_retired, 32'd2);

    jump = 1'b1;
    jump_index = 26'h010_0004;
    step();
    check("jmp_local_pc", a_pc, 32'h0040_0010);
    check("pc_plus4_comb", a_pc_plus4, 32'h0040_0014);

    jump = 1'b0;
    branch_taken = 1'b1;
    branch_offset = 16'hFFFC;
    step();
    check("br_neg_pc", a_pc, 32'h0040_0004);
    branch_offset = 16'h0002;
    step();
    check("br_pos2_pc", a_pc, 32'h0040_0010);
    branch_offset = 16'h0003;
    step();
    check("br_pos3_pc", a_pc, 32'h0040_0020);
    check("br_retired", a_retired, 32'd6);

    // Stall blocks a pending jump.
    branch_taken = 1'b0;
    jump = 1'b1;
    jump_index = 26'h3FF_FFFF;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", a_pc, 32'h0040_0020);
      check("stall_retired", a_retired, 32'd6);
    end
    stall = 1'b0;
    jump = 1'b0;
    step();
    check("unstall_pc", a_pc, 32'h0040_0024);
    check("unstall_retired", a_retired, 32'd7);

    // Halt wins over stall and jump.
    halt_req = 1'b1;
    stall = 1'b1;
    jump = 1'b1;
    step();
    check("halt_halted", 32'(a_halted), 32'd1);
    check("halt_fv", 32'(a_fetch_valid), 32'd0);
    check("halt_pc", a_pc, 32'h0040_0024);
    stall = 1'b0;
    jump = 1'b0;
    resume = 1'b1;
    step();
    check("halt_resume_both", 32'(a_halted), 32'd1);
    check("halt_hold_pc", a_pc, 32'h0040_0024);
    halt_req = 1'b0;
    step();
    check("resume_halted", 32'(a_halted), 32'd0);
    check("resume_fv", 32'(a_fetch_valid), 32'd1);
    check("resume_pc", a_pc, 32'h0040_0024);
    resume = 1'b0;
    step();
    check("post_resume_pc", a_pc, 32'h0040_0028);
    check("post_resume_retired", a_retired, 32'd8);

    // Asynchronous reset away from any edge.
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pc", a_pc, 32'h0040_0000);
    check("async_rst_retired", a_retired, 32'd0);
    check("async_rst_fv", 32'(a_fetch_valid), 32'd0);

    // Phase 2: halt_req/resume ignored in BOOT, jump in upper region, wrap.
    halt_req = 1'b1;
    resume = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    check("boot_ignore_halt", 32'(b_halted), 32'd0);
    check("boot_ignore_fv", 32'(b_fetch_valid), 32'd0);
    halt_req = 1'b0;
    resume = 1'b0;
    step();
    check("b_run_entry_fv", 32'(b_fetch_valid), 32'd1);
    check("c_boot_pc", c_pc, 32'hFFFF_FFF8);
    step();
    check("c_pc_fffc", c_pc, 32'hFFFF_FFFC);
    check("c_plus4_wrap", c_pc_plus4, 32'h0000_0000);
    step();
    check("c_wrap_pc", c_pc, 32'h0000_0000);
    check("c_wrap_retired", c_retired, 32'd2);
    check("b_pc_fffc", b_pc, 32'h8FFF_FFFC);

    jump = 1'b1;
    jump_index = 26'h000_0000;
    step();
    check("b_jmp_region", b_pc, 32'h9000_0000);
    branch_taken = 1'b1;
    branch_offset = 16'h0005;
    jump_index = 26'h000_0100;
    step();
    check("b_jmp_over_br", b_pc, 32'h9000_0400);
    check("b_jmp_retired", b_retired, 32'd4);
    check("b_jmp_plus4", b_pc_plus4, 32'h9000_0404);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter START_DELAY, default 1, meaning the number of cycles held in state BOOT after reset release (1..15).
REQ-003 SHALL have port clk, input, 1, single system clock, rising-edge active.
REQ-004 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port stall, input, 1, hold PC this cycle (hazard/memory wait).
REQ-006 SHALL have port branch_taken, input, 1, conditional branch resolved taken.
REQ-007 SHALL have port branch_offset, input, 16, signed word offset from the instruction immediate.
REQ-008 SHALL have port jump, input, 1, J-type jump.
REQ-009 SHALL have port jump_index, input, 26, instruction index field.
REQ-010 SHALL have port halt_req, input, 1, enter HALT.
REQ-011 SHALL have port resume, input, 1, leave HALT.
REQ-012 SHALL have port pc, output, 32, current fetch address (registered).
REQ-013 SHALL have port pc_plus4, output, 32, pc + 4 (combinational).
REQ-014 SHALL have port fetch_valid, output, 1, pc is a valid fetch address this cycle.
REQ-015 SHALL have port halted, output, 1, unit is in HALT.
REQ-016 SHALL have port retired_count, output, 32, count of PC advances since reset.

Function
REQ-017 SHALL implement states BOOT, RUN, HALT; reset enters BOOT.
REQ-018 SHALL, in BOOT, count START_DELAY cycles then go to RUN; pc held at RESET_PC; fetch_valid=0.
REQ-019 SHALL, in RUN, set fetch_valid=1 and advance pc on each rising edge where stall=0.
REQ-020 SHALL compute next pc by priority: jump -> {pc_plus4[31:28], jump_index, 2'b00}; else branch_taken -> pc_plus4 + (sign-extend(branch_offset) << 2); else pc_plus4.
REQ-021 SHALL perform all 32-bit additions modulo 2^32 (pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag).
REQ-022 SHALL, when stall=1 in RUN, hold pc and retired_count and ignore jump/branch_taken that cycle.
REQ-023 SHALL, on halt_req=1 in RUN, go to HALT next edge without advancing pc (halt_req overrides stall and jump/branch).
REQ-024 SHALL, in HALT, hold pc, drive fetch_valid=0, halted=1; resume=1 returns to RUN next edge with pc unchanged.
REQ-025 SHALL, with halt_req and resume both 1 in HALT, remain in HALT.
REQ-026 SHALL ignore halt_req and resume in BOOT.
REQ-027 SHALL increment retired_count by 1 on each pc advance, wrapping 32'hFFFF_FFFF -> 0.
REQ-028 SHALL have zero-cycle latency from pc to pc_plus4 and one-cycle latency from select inputs to pc.

Reset
REQ-029 SHALL, on reset_n=0, immediately and asynchronously force state=BOOT, pc=RESET_PC, retired_count=0, fetch_valid=0, halted=0, BOOT counter=0.
REQ-030 SHALL honour reset asserted mid-operation in any state with identical result; first RUN cycle after release is START_DELAY+1 edges later.

Structure
REQ-031 SHALL take state encoding (BOOT=2'b00, RUN=2'b01, HALT=2'b10) and the constant PC_STEP=4 from a shared package pc_pkg.
REQ-032 SHALL instantiate one sub-module pc_target_calc (combinational: pc_plus4, branch and jump targets); the state machine, pc register and counter stay in pc_next_unit.

Verification
REQ-033 Reset release, RESET_PC=32'h0040_0000, START_DELAY=1, no stall -> pc 0x00400000 for 2 edges, then 0x00400004, 0x00400008; fetch_valid rises at RUN entry.
REQ-034 pc=0x00400010, branch_taken=1, branch_offset=16'hFFFC -> next pc 0x00400004; branch_offset=16'h0003 -> 0x00400020.
REQ-035 pc=0x90000000, jump=1 with branch_taken=1, jump_index=26'h0000100 -> next pc 0x90000400; retired_count +1.
REQ-036 stall=1 for 3 cycles with jump=1 -> pc and retired_count unchanged; stall=0 -> pc_plus4 applied.
REQ-037 halt_req=1 with stall=1 in RUN -> HALT, halted=1, fetch_valid=0; resume with halt_req=1 -> stays HALT; resume alone -> RUN, same pc.
REQ-038 pc=0xFFFFFFFC, advance -> pc 0x00000000; reset_n pulsed low mid-RUN -> pc=RESET_PC and retired_count=0 without waiting for a clock edge.
